// File: rtl/mem_mod_dp.sv
// Simple-dual-port synchronous memory: byte-masked writes, 1- or 2-cycle reads,
// selectable collision behaviour and a hardware clear of the array after reset.
module mem_mod_dp #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  output logic                    wr_err,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    rd_err
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;

  typedef enum logic {StInit, StReady} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
  logic                    clr_we;
  logic                    ready;
  logic                    clr_last;
  logic                    wr_in_range, rd_in_range;
  logic                    wr_acc, wr_bad, rd_acc;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    s1_valid_q, s1_err_q;
  logic [DATA_WIDTH-1:0]   s1_data_q;
  logic                    wr_err_q;

  assign ready       = (state_q == StReady);
  assign init_busy   = ~ready;
  assign clr_last    = (32'(clr_ptr_q) == DEPTH - 1);
  assign wr_in_range = (32'(wr_addr) < DEPTH);
  assign rd_in_range = (32'(rd_addr) < DEPTH);
  assign wr_acc      = ready & wr_en & wr_in_range;
  assign wr_bad      = ready & wr_en & ~wr_in_range;
  assign rd_acc      = ready & rd_en;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_we    = 1'b0;
    unique case (state_q)
      StInit: begin
        clr_we    = 1'b1;
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_last) begin
          state_d   = StReady;
          clr_ptr_d = '0;
        end
      end
      StReady: begin
        state_d = StReady;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StInit;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Storage is not reset; the clear sequence zeroes it one word per cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) begin
        mem_q[clr_ptr_q] <= '0;
      end else if (wr_acc) begin
        for (int i = 0; i < NumBytes; i++) begin
          if (wr_be[i]) mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Write-first merges the incoming bytes into the word being read.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[rd_addr];
      if (BYPASS != 0 && wr_acc && wr_addr == rd_addr) begin
        for (int i = 0; i < NumBytes; i++) begin
          if (wr_be[i]) rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= rd_acc;
      s1_err_q   <= rd_acc & ~rd_in_range;
      wr_err_q   <= wr_bad;
      if (rd_acc) s1_data_q <= rd_word;
    end
  end

  assign wr_err = wr_err_q;

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  s2_valid_q, s2_err_q;
    logic [DATA_WIDTH-1:0] s2_data_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_err_q;
        if (s1_valid_q) s2_data_q <= s1_data_q;
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_err   = s2_err_q;
    assign rd_data  = s2_data_q;
  end else begin : g_lat1
    assign rd_valid = s1_valid_q;
    assign rd_err   = s1_err_q;
    assign rd_data  = s1_data_q;
  end

endmodule

// File: doc/mem_mod_dp.md
# mem_mod_dp

Parametrised simple-dual-port synchronous memory: the next generation of the team's single-port-arbitrated storage block. One read port and one write port operate in the same cycle, writes are byte-masked, read latency is selectable (1 or 2), same-address read/write collision behaviour is selectable, and the array is hardware-cleared to zero after reset. It is the general-purpose storage primitive for buffers, register files and lookup tables in the design.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- DEPTH, 16: number of words; any value ≥ 2, need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH): address width.
- RD_LATENCY, 1: read latency in cycles; legal values 1 or 2.
- BYPASS, 1: 1 = write-first (a colliding read returns the new data); 0 = read-first (returns the old data).

- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- init_busy  out  1  high while the array is being cleared; ports ignored.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_be  in  DATA_WIDTH/8  byte enables; bit i gates wr_data[8i+7:8i].
- wr_err  out  1  one-cycle pulse: write dropped (address ≥ DEPTH).
- rd_en  in  1  read request.
- rd_addr  in  ADDR_WIDTH  read address.
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data carries the result of an accepted read.
- rd_err  out  1  accepted read had address ≥ DEPTH; aligned with rd_valid.

## Operation
- Reset values: init_busy=1, rd_data=0, rd_valid=0, rd_err=0, wr_err=0; all read pipeline stages clear; clear pointer = 0; state = INIT.
- State machine, two states:
  - INIT: one word per cycle at the clear pointer is written to 0, pointer increments; after word DEPTH-1 is written, the next state is READY. While rst is high, the state is held in INIT with the pointer at 0.
  - READY: normal operation; init_busy=0. Asserting rst in any state (including mid-clear) returns to INIT with the pointer at 0 and restarts the clear.
- In INIT, rd_en and wr_en are ignored: no writes, no rd_valid, no error pulses.
- Write (READY, wr_en=1, wr_addr<DEPTH): each byte lane with wr_be=1 is updated; other lanes are unchanged. wr_be=0 with wr_en=1 is a legal no-op (no error).
- Write with wr_addr ≥ DEPTH: array is unchanged; wr_err=1 on the next cycle for one cycle.
- Read (READY, rd_en=1): accepted every cycle; no backpressure. For rd_addr ≥ DEPTH, the result is rd_data=0 with rd_err=1.
- Collision (rd_en and wr_en in the same cycle at the same in-range address):
  - BYPASS=1 returns the merged word: new bytes where wr_be=1, old bytes elsewhere.
  - BYPASS=0 returns the pre-write word.
- Read and write at different addresses in the same cycle are fully independent. There is no read/write priority.
- rd_data holds its last value while rd_valid=0.

## Timing
- Write: the array is updated at the edge sampling wr_en. A read issued in a later cycle sees the new data.
- RD_LATENCY=1: rd_en sampled at edge N → rd_data/rd_valid/rd_err registered at edge N, visible during cycle N+1.
- RD_LATENCY=2: one further register stage; the result is visible during cycle N+2. Back-to-back reads give back-to-back rd_valid.
- rd_valid is high for exactly one cycle per accepted read.
- wr_err: registered at the edge sampling the bad write; high for one cycle.
- Clear: with rst sampled high at edge R and low at R+1, init_busy is high through cycle R+DEPTH and low from cycle R+DEPTH+1. The first accepted request is the one sampled at edge R+DEPTH+1.
- Reads in flight when rst is asserted are discarded: rd_valid=0 after the reset edge.

## Test plan
- Clear: fill every word with 0xFFFFFFFF, assert rst for one cycle, then read all DEPTH words after init_busy falls → all reads return 0x00000000. init_busy is high for exactly DEPTH cycles after rst releases. rd_en during INIT → no rd_valid.
- Byte enables: write 0x11223344 to addr 3 with be=1111, then 0xAABBCCDD with be=0101, then read addr 3 → 0x11BB33DD.
- Collision: write 0xDEADBEEF to addr 5; the next cycle write 0x12345678 be=1111 and read addr 5 together → BYPASS=1 returns 0x12345678, BYPASS=0 returns 0xDEADBEEF.
- Latency/throughput: issue reads on 8 consecutive cycles with RD_LATENCY=1 and =2 → 8 consecutive rd_valid pulses starting 1 or 2 cycles after the first request, with data in address order.
- Out of range (DEPTH=12):
  - write addr 13 → wr_err pulses once, and a read of all 12 words shows no change.
  - read addr 15 → rd_valid=1, rd_err=1, rd_data=0.
- Reset mid-clear: assert rst when the clear pointer is at DEPTH/2 → the pointer restarts at 0, and init_busy stays high for a full DEPTH cycles after the release.
